bus_ram_responder: RTL and testbench
====================================

BUS_RAM_RESPONDER -- requirements
Module: bus_ram_responder

Interface
REQ-001 SHALL have parameter ADDR_BASE, default 32'h0001_0000, byte address of word 0.
REQ-002 SHALL have parameter WORDS, default 2048, RAM depth in 32-bit words, power of two.
REQ-003 SHALL have parameter LATENCY, default 1, edges from request accept to o_ready high, legal range 1..15.
REQ-004 SHALL have port i_clock  in  1  clock; all state changes on rising edge.
REQ-005 SHALL have port i_reset  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port i_request  in  1  initiator access request, held high until o_ready seen.
REQ-007 SHALL have port i_rw  in  1  0 = read, 1 = write; valid while i_request high.
REQ-008 SHALL have port i_address  in  32  byte address; bits [1:0] ignored.
REQ-009 SHALL have port i_data  in  32  write data from initiator.
REQ-010 SHALL have port o_data  out  32  read data to initiator; holds the written word after a write.
REQ-011 SHALL have port o_ready  out  1  access complete; held until i_request falls.

Function
REQ-012 SHALL decode a hit as ADDR_BASE <= i_address < ADDR_BASE + 4*WORDS; index = (i_address - ADDR_BASE) >> 2.
REQ-013 SHALL implement states IDLE, WAIT, DONE.
REQ-014 IDLE: on an edge with i_request=1 and hit, SHALL latch index, i_rw and i_data, load counter with LATENCY-1, and go to WAIT.
REQ-015 IDLE: SHALL ignore a miss (no state change, o_ready stays 0) so another responder can serve it.
REQ-016 WAIT, counter != 0: SHALL decrement the counter.
REQ-017 WAIT, counter == 0, read: SHALL set o_data <= mem[index], set o_ready <= 1, and go to DONE.
REQ-018 WAIT, counter == 0, write: SHALL set mem[index] <= latched data, o_data <= latched data, o_ready <= 1, and go to DONE.
REQ-019 SHALL assert o_ready after edge N+LATENCY when the request is accepted at edge N.
REQ-020 DONE: while i_request=1, SHALL hold o_ready=1 and o_data stable.
REQ-021 DONE: on the first edge with i_request=0, SHALL clear o_ready and go to IDLE; a new request is accepted no earlier than the following edge.
REQ-022 i_request falling in WAIT (protocol violation) SHALL abort: go to IDLE, o_ready stays 0, no memory write.
REQ-023 SHALL ignore changes to i_address, i_rw and i_data after acceptance.
REQ-024 SHALL write full words only; there are no byte enables.
REQ-025 o_data SHALL change only on a completing access or reset.

Reset
REQ-026 i_reset SHALL force state=IDLE, o_ready=0, o_data=0, counter=0, and clear the latched fields immediately, independent of the clock.
REQ-027 Reset mid-access SHALL drop the access; a write in WAIT is not performed.
REQ-028 Reset SHALL NOT clear RAM contents.

Structure
REQ-029 A shared bus package SHALL hold the state encoding (IDLE=2'd0, WAIT=2'd1, DONE=2'd2) and the bus data/address width constants (32).
REQ-030 The storage array SHALL be a sub-module bus_ram_array: single port, synchronous write, word-indexed, log2(WORDS) address bits.
REQ-031 Implementation SHALL be 120-400 lines of RTL total.

Verification
REQ-032 Write then read, LATENCY=1: write 32'hDEAD_BEEF to 32'h0001_0010, then read 32'h0001_0010 -> o_ready high one edge after each accept; read o_data = 32'hDEAD_BEEF.
REQ-033 LATENCY=4: read at 32'h0001_0000 accepted at edge N -> o_ready 0 through edge N+3, 1 after edge N+4.
REQ-034 Miss: request at 32'h0000_0000 and at ADDR_BASE+4*WORDS held 20 cycles -> o_ready stays 0 and memory is unchanged.
REQ-035 Back-to-back: request drops one cycle after ready and re-asserts the next cycle with a new address -> second access completes with correct data; o_ready low for at least one cycle between accesses.
REQ-036 Abort and reset: request dropped in WAIT (LATENCY=8), then i_reset pulsed mid-WAIT of a write of 32'h1234_5678 -> o_ready 0, o_data 0, target word keeps its old value.
REQ-037 Address bits [1:0] ignored: write to 32'h0001_0023, read 32'h0001_0020 -> data matches.

Source files
------------

// File: rtl/bus_ram_responder_pkg.sv
// Shared bus definitions for the RAM responder: FSM state encoding and bus widths.
package bus_ram_responder_pkg;

    localparam int unsigned BUS_DW = 32;
    localparam int unsigned BUS_AW = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bus_ram_responder_ram_array.sv
// Single-port word-indexed storage: synchronous write, combinational read of the
// addressed word so the responder can capture it on the completing edge.
module bus_ram_array
    import bus_ram_responder_pkg::*;
#(
    parameter int unsigned WORDS = 2048,
    parameter int unsigned AW    = $clog2(WORDS)
) (
    input  logic              i_clock,
    input  logic              i_we,
    input  logic [AW-1:0]     i_addr,
    input  logic [BUS_DW-1:0] i_wdata,
    output logic [BUS_DW-1:0] o_rdata
);

    logic [BUS_DW-1:0] mem_q [WORDS];

    always_ff @(posedge i_clock) begin
        if (i_we) begin
            mem_q[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = mem_q[i_addr];

endmodule

// File: rtl/bus_ram_responder.sv
// Bus slave answering word accesses inside its address window after a fixed
// latency; misses are ignored so another responder on the bus can serve them.
module bus_ram_responder
    import bus_ram_responder_pkg::*;
#(
    parameter logic [BUS_AW-1:0] ADDR_BASE = 32'h0001_0000,
    parameter int unsigned       WORDS     = 2048,
    parameter int unsigned       LATENCY   = 1
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_request,
    input  logic              i_rw,
    input  logic [BUS_AW-1:0] i_address,
    input  logic [BUS_DW-1:0] i_data,
    output logic [BUS_DW-1:0] o_data,
    output logic              o_ready
);

    localparam int unsigned AW = $clog2(WORDS);
    // Window size kept one bit wider than the bus so a window ending at 2^32 cannot wrap.
    localparam logic [BUS_AW:0] SPAN = (BUS_AW+1)'(64'(WORDS) << 2);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [AW-1:0]     index_q, index_d;
    logic              rw_q, rw_d;
    logic [BUS_DW-1:0] wdata_q, wdata_d;
    logic [BUS_DW-1:0] rdata_q, rdata_d;
    logic              ready_q, ready_d;

    logic [BUS_AW-1:0] offset;
    logic              hit;
    logic [AW-1:0]     index;
    logic              ram_we;
    logic [BUS_DW-1:0] ram_rdata;

    assign offset = i_address - ADDR_BASE;
    assign hit    = (i_address >= ADDR_BASE) && ({1'b0, offset} < SPAN);
    assign index  = AW'(offset >> 2);

    // The write lands on the completing edge only; an abort or reset in WAIT never reaches it.
    assign ram_we = (state_q == WAIT) && i_request && (cnt_q == '0) && rw_q;

    bus_ram_array #(
        .WORDS (WORDS),
        .AW    (AW)
    ) u_array (
        .i_clock (i_clock),
        .i_we    (ram_we),
        .i_addr  (index_q),
        .i_wdata (wdata_q),
        .o_rdata (ram_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        index_d = index_q;
        rw_d    = rw_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ready_d = ready_q;
        unique case (state_q)
            IDLE: begin
                if (i_request && hit) begin
                    state_d = WAIT;
                    cnt_d   = 4'(LATENCY - 1);
                    index_d = index;
                    rw_d    = i_rw;
                    wdata_d = i_data;
                end
            end
            WAIT: begin
                if (!i_request) begin
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rdata_d = rw_q ? wdata_q : ram_rdata;
                    ready_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!i_request) begin
                    ready_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            index_q <= '0;
            rw_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            index_q <= index_d;
            rw_q    <= rw_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
        end
    end

    assign o_data  = rdata_q;
    assign o_ready = ready_q;

endmodule

// File: tb/tb_bus_ram_responder.sv
// Directed plus randomized checks of three responders (latency 1, 4, 8) against
// a word-addressed memory model held in an associative array.
module tb_bus_ram_responder;

    localparam logic [31:0] BASE  = 32'h0001_0000;
    localparam int unsigned WORDS = 2048;
    localparam int          LATS [3] = '{1, 4, 8};

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req;
    logic        rw_s;
    logic [31:0] addr_s;
    logic [31:0] wd_s;
    logic [2:0]  rdy;
    logic [31:0] rd [3];

    int unsigned vectors = 0;
    int unsigned errs    = 0;
    logic [31:0] mdl [int unsigned];

    always #5 clk = ~clk;

    bus_ram_responder #(.ADDR_BASE(BASE), .WORDS(WORDS), .LATENCY(1)) u_l1 (
        .i_clock(clk), .i_reset(reset), .i_request(req[0]), .i_rw(rw_s),
        .i_address(addr_s), .i_data(wd_s), .o_data(rd[0]), .o_ready(rdy[0]));
    bus_ram_responder #(.ADDR_BASE(BASE), .WORDS(WORDS), .LATENCY(4)) u_l4 (
        .i_clock(clk), .i_reset(reset), .i_request(req[1]), .i_rw(rw_s),
        .i_address(addr_s), .i_data(wd_s), .o_data(rd[1]), .o_ready(rdy[1]));
    bus_ram_responder #(.ADDR_BASE(BASE), .WORDS(WORDS), .LATENCY(8)) u_l8 (
        .i_clock(clk), .i_reset(reset), .i_request(req[2]), .i_rw(rw_s),
        .i_address(addr_s), .i_data(wd_s), .o_data(rd[2]), .o_ready(rdy[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned key_of(input int i, input logic [31:0] a);
        return 32'(i) * 65536 + ((a - BASE) >> 2);
    endfunction

    // One complete handshake; inputs are scrambled right after acceptance.
    task automatic access(input int i, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input int hold, output logic [31:0] got);
        int          edges;
        logic [31:0] exp;
        @(negedge clk);
        req[i] = 1'b1; rw_s = w; addr_s = a; wd_s = d;
        edges = 0;
        do begin
            @(posedge clk); #1;
            edges++;
            if (edges == 1) begin
                addr_s = $urandom; wd_s = $urandom; rw_s = ~w;
            end
        end while (!rdy[i] && edges < 40);
        check("latency", 32'(edges), 32'(LATS[i] + 1));
        if (w) mdl[key_of(i, a)] = d;
        exp = mdl[key_of(i, a)];
        got = rd[i];
        check(w ? "wr_echo" : "rd_data", got, exp);
        repeat (hold) begin
            @(posedge clk); #1;
            check("hold_rdy", 32'(rdy[i]), 32'd1);
            check("hold_data", rd[i], got);
        end
        @(negedge clk);
        req[i] = 1'b0;
        @(posedge clk); #1;
        check("rdy_drop", 32'(rdy[i]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0]  got, a, d, old, keep;
        int unsigned  q[$];

        reset = 1'b1; req = '0; rw_s = 1'b0; addr_s = '0; wd_s = '0;
        #2;
        for (int i = 0; i < 3; i++) begin
            check("rst_rdy", 32'(rdy[i]), 32'd0);
            check("rst_data", rd[i], 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;

        // Write then read at latency 1
        access(0, 1'b1, 32'h0001_0010, 32'hDEAD_BEEF, 0, got);
        access(0, 1'b0, 32'h0001_0010, 32'h0, 1, got);
        check("wr_rd_beef", got, 32'hDEAD_BEEF);

        // Latency 4 read of word 0
        access(1, 1'b1, 32'h0001_0000, 32'h0BAD_F00D, 0, got);
        access(1, 1'b0, 32'h0001_0000, 32'h0, 0, got);
        check("l4_word0", got, 32'h0BAD_F00D);

        // Low address bits ignored
        access(0, 1'b1, 32'h0001_0023, 32'hCAFE_0123, 0, got);
        access(0, 1'b0, 32'h0001_0020, 32'h0, 0, got);
        check("lowbits", got, 32'hCAFE_0123);

        // Last word of the window
        access(0, 1'b1, BASE + 4 * WORDS - 4, 32'h7777_AAAA, 0, got);
        access(0, 1'b0, BASE + 4 * WORDS - 1, 32'h0, 0, got);
        check("top_word", got, 32'h7777_AAAA);

        // Misses below and just above the window
        keep = rd[0];
        for (int m = 0; m < 2; m++) begin
            @(negedge clk);
            req[0] = 1'b1; rw_s = 1'b1; wd_s = 32'h5555_5555;
            addr_s = (m == 0) ? 32'h0000_0000 : BASE + 4 * WORDS;
            repeat (20) begin
                @(posedge clk); #1;
                check("miss_rdy", 32'(rdy[0]), 32'd0);
            end
            check("miss_data", rd[0], keep);
            @(negedge clk);
            req[0] = 1'b0;
        end
        access(0, 1'b0, 32'h0001_0010, 32'h0, 0, got);
        check("miss_mem", got, 32'hDEAD_BEEF);
        access(0, 1'b0, BASE + 4 * WORDS - 4, 32'h0, 0, got);
        check("miss_top", got, 32'h7777_AAAA);

        // Abort in WAIT at latency 8
        old = 32'hA5A5_0001;
        access(2, 1'b1, 32'h0001_0040, old, 0, got);
        keep = rd[2];
        @(negedge clk);
        req[2] = 1'b1; rw_s = 1'b1; addr_s = 32'h0001_0040; wd_s = 32'hBAD0_0BAD;
        repeat (3) begin
            @(posedge clk); #1;
            check("abort_wait", 32'(rdy[2]), 32'd0);
        end
        @(negedge clk);
        req[2] = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            check("abort_rdy", 32'(rdy[2]), 32'd0);
        end
        check("abort_data", rd[2], keep);
        access(2, 1'b0, 32'h0001_0040, 32'h0, 0, got);
        check("abort_mem", got, old);

        // Asynchronous reset mid-WAIT of a write
        @(negedge clk);
        req[2] = 1'b1; rw_s = 1'b1; addr_s = 32'h0001_0040; wd_s = 32'h1234_5678;
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("rst_mid_rdy", 32'(rdy[2]), 32'd0);
        check("rst_mid_data", rd[2], 32'd0);
        @(negedge clk);
        req[2] = 1'b0;
        @(posedge clk); #1;
        check("rst_hold_rdy", 32'(rdy[2]), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        access(2, 1'b0, 32'h0001_0040, 32'h0, 0, got);
        check("rst_mem", got, old);

        // Randomized back-to-back traffic on every instance
        for (int i = 0; i < 3; i++) begin
            q.delete();
            for (int n = 0; n < 12; n++) begin
                if (q.size() == 0 || $urandom_range(0, 1) == 1) begin
                    a = BASE + 4 * $urandom_range(0, WORDS - 1) + $urandom_range(0, 3);
                    d = $urandom;
                    access(i, 1'b1, a, d, $urandom_range(0, 2), got);
                    q.push_back(a);
                end else begin
                    a = q[$urandom_range(0, q.size() - 1)];
                    access(i, 1'b0, a, 32'h0, $urandom_range(0, 2), got);
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
